// File: rtl/spectrum_stream_tx.sv
// spectrum_stream_tx: serializes a snapshot of NUM_BANDS band words into one
// Avalon-ST packet per frame (sop on band 0, eop on band NUM_BANDS-1).
// A single pending snapshot absorbs a frame that arrives mid-packet.
// Optional build macro SPECTRUM_TX_ABS_EN: o_data carries the saturated
// absolute value of the band word instead of the raw word.
//
// Handshake: a beat transfers on a rising edge where o_valid && i_ready.
// While o_valid=1 and i_ready=0 the beat (o_data/o_index/o_sop/o_eop) holds.
// o_valid never depends on i_ready, and i_ready is ignored while o_valid=0.
module spectrum_stream_tx #(
  parameter int NUM_BANDS = 16,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 4
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_BANDS-1:0][DATA_W-1:0]  i_bands,
  input  logic                              i_load,
  input  logic                              i_ready,
  output logic                              o_valid,
  output logic                              o_sop,
  output logic                              o_eop,
  output logic [DATA_W-1:0]                 o_data,
  output logic [IDX_W-1:0]                  o_index,
  output logic                              o_busy,
  output logic [15:0]                       o_pkt_count,
  output logic [7:0]                        o_drop_count,
  output logic                              o_dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

  state_t                             state_q, state_d;
  logic [NUM_BANDS-1:0][DATA_W-1:0]   active_q, active_d;
  logic [NUM_BANDS-1:0][DATA_W-1:0]   pending_q, pending_d;
  logic                               pend_q, pend_d;
  logic [IDX_W-1:0]                   index_q, index_d;
  logic [15:0]                        pkt_count_q, pkt_count_d;
  logic [7:0]                         drop_count_q, drop_count_d;

  logic                               xfer;
  logic                               last_beat;
  logic [7:0]                         drop_inc;
  logic [DATA_W-1:0]                  raw_word;

  // State and data registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      active_q     <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      index_q      <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_q       <= pend_d;
      index_q      <= index_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Next-state: load, advance on transfer, chain packets at eop, stash frames.
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    pending_d    = pending_q;
    pend_d       = pend_q;
    index_d      = index_q;
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;

    xfer      = (state_q == S_SEND) && i_ready;
    last_beat = (index_q == LAST_IDX);
    drop_inc  = (drop_count_q == 8'hFF) ? drop_count_q : drop_count_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (i_load) begin
          active_d = i_bands;
          index_d  = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (xfer && last_beat) begin
          pkt_count_d = pkt_count_q + 16'd1;
          if (pend_q) begin
            // Promote the stashed frame; a same-cycle load refills the stash
            // so nothing is lost and no drop is counted.
            active_d = pending_q;
            index_d  = '0;
            if (i_load) begin
              pending_d = i_bands;
            end else begin
              pend_d = 1'b0;
            end
          end else if (i_load) begin
            active_d = i_bands;
            index_d  = '0;
          end else begin
            index_d = '0;
            state_d = S_IDLE;
          end
        end else begin
          if (xfer) begin
            index_d = index_q + IDX_W'(1);
          end
          // Mid-packet frames go to the stash; the active packet is untouched.
          if (i_load) begin
            pending_d = i_bands;
            pend_d    = 1'b1;
            if (pend_q) begin
              drop_count_d = drop_inc;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output word path: raw band word, or its saturated magnitude.
  always_comb begin
    raw_word = active_q[index_q];
`ifdef SPECTRUM_TX_ABS_EN
    if (!raw_word[DATA_W-1]) begin
      o_data = raw_word;
    end else if (raw_word == {1'b1, {(DATA_W-1){1'b0}}}) begin
      o_data = {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      o_data = ~raw_word + {{(DATA_W-1){1'b0}}, 1'b1};
    end
`else
    o_data = raw_word;
`endif
  end

  assign o_valid      = (state_q == S_SEND);
  assign o_sop        = o_valid && (index_q == '0);
  assign o_eop        = o_valid && last_beat;
  assign o_index      = index_q;
  assign o_busy       = (state_q == S_SEND) || pend_q;
  assign o_pkt_count  = pkt_count_q;
  assign o_drop_count = drop_count_q;
  assign o_dbg_state  = state_q;

endmodule
